// File: rtl/req_pacer_pkg.sv
// Shared types and parameter limits for the req_pacer_arb request sequencer.
package req_pacer_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } state_e;

  localparam int NUM_REQ_MIN = 2;
  localparam int NUM_REQ_MAX = 16;
  localparam int MIN_GAP_MAX = 255;
  localparam int TIMEOUT_MIN = 1;
  localparam int GAP_CNT_W   = 8;

endpackage

// File: rtl/req_pacer_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import req_pacer_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [ID_W-1:0]    win_id,
  output logic               valid
);

  localparam int SUM_W = ID_W + 1;

  logic [SUM_W-1:0] sum;
  logic [ID_W-1:0]  idx;

  always_comb begin
    // NOTE: every output and temporary gets a default first so no path leaves them unassigned (no latch).
    win    = '0;
    win_id = '0;
    valid  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + SUM_W'(k);
      if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
      idx = sum[ID_W-1:0];
      if (!valid && req[idx]) begin
        valid    = 1'b1;
        win[idx] = 1'b1;
        win_id   = idx;
      end
    end
  end

endmodule

// File: rtl/req_pacer_arb.sv
// Round-robin arbiter that issues one-cycle resource requests, waits for done or
// timeout, then holds off for MIN_GAP cycles before the next grant.
module req_pacer_arb
  import req_pacer_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MIN_GAP = 1,
  parameter int TIMEOUT = 16,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_in,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               res_req,
  input  logic               res_done,
  output logic               busy,
  output logic               timeout_err
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TIMEOUT_V = WCNT_W'(TIMEOUT);

  if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
    $error("req_pacer_arb: NUM_REQ must be in 2..16");
  end
  if (MIN_GAP < 0 || MIN_GAP > MIN_GAP_MAX) begin : g_bad_min_gap
    $error("req_pacer_arb: MIN_GAP must be in 0..255");
  end
  if (TIMEOUT < TIMEOUT_MIN) begin : g_bad_timeout
    $error("req_pacer_arb: TIMEOUT must be at least 1");
  end

  state_e                state;
  logic [ID_W-1:0]       ptr;
  logic [WCNT_W-1:0]     wait_cnt;
  logic [GAP_CNT_W-1:0]  gap_cnt;

  logic [NUM_REQ-1:0]    pick_win;
  logic [ID_W-1:0]       pick_id;
  logic                  pick_valid;
  logic [ID_W-1:0]       ptr_next;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req_in),
    .ptr    (ptr),
    .win    (pick_win),
    .win_id (pick_id),
    .valid  (pick_valid)
  );

  assign ptr_next = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + ID_W'(1);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      gnt         <= '0;
      gnt_id      <= '0;
      res_req     <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      ptr         <= '0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            state   <= S_ISSUE;
            gnt     <= pick_win;
            gnt_id  <= pick_id;
            res_req <= 1'b1;
            busy    <= 1'b1;
            ptr     <= ptr_next;
          end
        end
        S_ISSUE: begin
          // A done seen while the request is still on the wire is stale and dropped.
          state    <= S_WAIT_DONE;
          res_req  <= 1'b0;
          wait_cnt <= WCNT_W'(1);
        end
        S_WAIT_DONE: begin
          if (res_done || wait_cnt == TIMEOUT_V) begin
            if (!res_done) timeout_err <= 1'b1;
            gnt <= '0;
            if (MIN_GAP == 0) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= S_GAP;
              gap_cnt <= GAP_CNT_W'(MIN_GAP);
            end
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        S_GAP: begin
          if (gap_cnt < GAP_CNT_W'(2)) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt - GAP_CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  a_req_pulse: assert property (@(posedge clk) disable iff (rst) res_req |=> !res_req)
    else $error("req_pacer_arb: res_req high on consecutive cycles");
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
    else $error("req_pacer_arb: gnt not one-hot-or-zero");
  a_req_gnt: assert property (@(posedge clk) disable iff (rst) res_req |-> $onehot(gnt))
    else $error("req_pacer_arb: res_req without a single grant");

endmodule

// File: tb/tb_req_pacer_arb.sv
// Randomized self-checking bench for req_pacer_arb against a cycle-time reference model.
module tb_req_pacer_arb;

  localparam int N   = 4;
  localparam int GAP = 1;
  localparam int TO  = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req_in = '0;
  logic         res_done = 1'b0;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         res_req, busy, timeout_err;

  logic         res_done2 = 1'b0;
  logic [N-1:0] gnt2;
  logic [1:0]   gnt_id2;
  logic         res_req2, busy2, timeout_err2;

  always #5 clk = ~clk;

  req_pacer_arb #(.NUM_REQ(N), .MIN_GAP(GAP), .TIMEOUT(TO)) u_dut (
    .clk(clk), .rst(rst), .req_in(req_in), .gnt(gnt), .gnt_id(gnt_id),
    .res_req(res_req), .res_done(res_done), .busy(busy), .timeout_err(timeout_err)
  );

  req_pacer_arb #(.NUM_REQ(N), .MIN_GAP(0), .TIMEOUT(4)) u_dut_gap0 (
    .clk(clk), .rst(rst), .req_in(req_in), .gnt(gnt2), .gnt_id(gnt_id2),
    .res_req(res_req2), .res_done(res_done2), .busy(busy2), .timeout_err(timeout_err2)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model, expressed as transaction times rather than states.
  bit m_in      = 1'b0;
  int m_issue   = -100;
  int m_win     = 0;
  int m_ptr     = 0;
  int m_free    = 0;
  bit m_err     = 1'b0;
  int dly       = 0;
  bit issue_done = 1'b0;

  bit rand_mode      = 1'b0;
  int d_dly          = 1;
  bit d_issue_done   = 1'b0;

  bit         e_req, e_busy, e_err;
  logic [N-1:0] e_gnt;
  int         e_id;

  int last_pulse = -1;
  int order_q[$];
  int space_q[$];
  int last2 = -1;
  int pulses2 = 0;
  bit prev2 = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  task automatic model(input logic [N-1:0] r, input logic d, input bit rs);
    int c;
    c = cyc;
    if (rs) begin
      m_in = 1'b0; m_ptr = 0; m_err = 1'b0; m_win = 0; m_free = c + 1; m_issue = -100;
    end else if (m_in && c > m_issue && (d || c == m_issue + TO)) begin
      if (!d) m_err = 1'b1;
      m_in   = 1'b0;
      m_free = c + 1 + GAP;
    end else if (!m_in && c >= m_free && r != '0) begin
      m_win   = rr(r, m_ptr);
      m_ptr   = (m_win + 1) % N;
      m_in    = 1'b1;
      m_issue = c + 1;
      dly        = rand_mode ? int'($urandom_range(1, TO + 2)) : d_dly;
      issue_done = rand_mode ? ($urandom_range(0, 3) == 0) : d_issue_done;
    end
    e_req  = m_in && (c + 1 == m_issue);
    e_gnt  = m_in ? (N'(1) << m_win) : '0;
    e_id   = m_win;
    e_busy = m_in || (c + 1 < m_free);
    e_err  = m_err;
  endtask

  task automatic step(input logic [N-1:0] r, input bit rs);
    logic d;
    d = m_in && ((cyc == m_issue + dly) || (issue_done && cyc == m_issue));
    req_in    = r;
    res_done  = d;
    rst       = rs;
    res_done2 = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    model(r, d, rs);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("res_req", 32'(res_req), 32'(e_req));
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("gnt_id", 32'(gnt_id), 32'(e_id));
    check("busy", 32'(busy), 32'(e_busy));
    check("timeout_err", 32'(timeout_err), 32'(e_err));
    if (rs) last_pulse = -1;
    if (res_req === 1'b1) begin
      if (last_pulse >= 0) space_q.push_back(cyc - last_pulse);
      order_q.push_back(int'(gnt_id));
      last_pulse = cyc;
    end
    check("gap0_b2b", 32'(res_req2 & prev2), 32'd0);
    if (rs) begin
      last2 = -1;
      prev2 = 1'b0;
    end else begin
      if (res_req2 === 1'b1) begin
        pulses2++;
        check("gap0_req_gnt", 32'($onehot(gnt2)), 32'd1);
        if (last2 >= 0) check("gap0_space_ge3", 32'((cyc - last2) >= 3), 32'd1);
        last2 = cyc;
      end
      prev2 = res_req2;
    end
  endtask

  task automatic clear_obs();
    order_q.delete();
    space_q.delete();
  endtask

  initial begin
    logic [N-1:0] r;
    int exp_order[5];
    int first_id;

    exp_order = '{0, 1, 2, 3, 0};

    // Reset state.
    step('0, 1'b1);
    step('0, 1'b1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);

    // Single requester, done three cycles after the pulse.
    clear_obs();
    d_dly = 3; d_issue_done = 1'b0;
    for (int i = 0; i < 12; i++) step((i < 5) ? 4'b0010 : 4'b0000, 1'b0);
    check("single_pulses", 32'(order_q.size()), 32'd1);
    if (order_q.size() > 0) check("single_id", 32'(order_q[0]), 32'd1);

    // All requesting, immediate done: rotation and exact pulse spacing.
    step('0, 1'b1);
    clear_obs();
    d_dly = 1;
    for (int i = 0; i < 25; i++) step(4'b1111, 1'b0);
    check("rr_count", 32'(order_q.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < order_q.size(); i++) check("rr_order", 32'(order_q[i]), 32'(exp_order[i]));
    for (int i = 0; i < 4 && i < space_q.size(); i++) check("rr_spacing", 32'(space_q[i]), 32'(3 + GAP));

    // Timeout with no done; error stays sticky through a good transaction.
    step('0, 1'b1);
    clear_obs();
    d_dly = 100;
    for (int i = 0; i < 25; i++) step((i == 0) ? 4'b0001 : 4'b0000, 1'b0);
    check("to_err_set", 32'(timeout_err), 32'd1);
    d_dly = 2;
    for (int i = 0; i < 10; i++) step((i == 0) ? 4'b1000 : 4'b0000, 1'b0);
    check("to_err_sticky", 32'(timeout_err), 32'd1);
    step('0, 1'b1);
    check("to_err_rst", 32'(timeout_err), 32'd0);

    // Done in ISSUE ignored; done on the final timeout cycle counts as completion.
    clear_obs();
    d_dly = TO; d_issue_done = 1'b1;
    for (int i = 0; i < 25; i++) step((i == 0) ? 4'b0100 : 4'b0000, 1'b0);
    check("edge_done_err", 32'(timeout_err), 32'd0);
    check("edge_done_pulses", 32'(order_q.size()), 32'd1);
    d_issue_done = 1'b0;

    // Reset during WAIT_DONE, requester 2 still requesting afterwards.
    d_dly = 100;
    step(4'b0001, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b1);
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_req", 32'(res_req), 32'd0);
    clear_obs();
    d_dly = 2;
    for (int i = 0; i < 4; i++) step(4'b0100, 1'b0);
    first_id = (order_q.size() > 0) ? order_q[0] : -1;
    check("midrst_first_id", 32'(first_id), 32'd2);

    // Randomized traffic against the model.
    rand_mode = 1'b1;
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      step(r, $urandom_range(0, 399) == 0);
    end
    check("gap0_active", 32'(pulses2 > 0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/req_pacer_arb.md
# req_pacer_arb

Round-robin arbiter and sequencer that shares one single-outstanding resource among NUM_REQ requesters. It issues the resource request strictly as a one-cycle pulse and never back-to-back, so the resource-side property `req |=> !req` holds by construction. It waits for completion, or times out, then enforces a programmable idle gap before the next grant. It sits between requester agents and the shared resource, and is the only driver of the resource `req` line.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..16.
- MIN_GAP, 1: idle cycles forced after each completion before the next issue; legal range 0..255.
- TIMEOUT, 16: maximum cycles spent in WAIT_DONE before abort; legal range ≥1.
- ID_W, $clog2(NUM_REQ): width of grant index (derived localparam, not overridable).

- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- req_in  in  NUM_REQ  level request per requester; held until its gnt deasserts.
- gnt  out  NUM_REQ  one-hot grant; held from ISSUE through WAIT_DONE.
- gnt_id  out  ID_W  index of the current or last winner.
- res_req  out  1  single-cycle request pulse to the resource.
- res_done  in  1  resource completion pulse.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky abort flag; cleared only by rst.

## Operation
- FSM states: IDLE, ISSUE, WAIT_DONE, GAP. The state enum lives in the package.
- IDLE:
  - If any req_in is set, pick the winner by round robin starting at the priority pointer `ptr`.
  - Go to ISSUE, register gnt, gnt_id and res_req=1.
- ISSUE:
  - Lasts exactly one cycle; res_req=1 only here.
  - res_done sampled in ISSUE is ignored.
  - Always go to WAIT_DONE.
- WAIT_DONE:
  - res_req=0; gnt is held.
  - On res_done: clear gnt, go to GAP (or to IDLE if MIN_GAP==0).
  - If the wait counter reaches TIMEOUT without res_done: set timeout_err, clear gnt, go to GAP/IDLE as above.
  - res_done and timeout expiry in the same cycle: done wins, no error.
- GAP:
  - The down-counter loads MIN_GAP on entry; go to IDLE when it reaches 1.
  - req_in is ignored during GAP.
- Pointer: at each grant, `ptr` ← (winner+1) mod NUM_REQ. Reset value 0, so requester 0 has priority first.
- A requester dropping req_in after grant does not abort the transaction.
- Wait-counter width is $clog2(TIMEOUT+1). Gap-counter width is 8 bits. No wrap is reachable.
- Embedded concurrent assertions:
  - res_req |=> !res_req
  - $onehot0(gnt)
  - res_req implies $onehot(gnt)
  - Action blocks use $error only, never $fatal.

## Timing
- Reset values: state IDLE, gnt=0, gnt_id=0, res_req=0, busy=0, timeout_err=0, ptr=0, all counters 0.
- All outputs are registered.
- Request-to-issue latency: req_in high in cycle N while IDLE gives res_req and gnt high in cycle N+1.
- Minimum spacing between res_req pulses: 3+MIN_GAP cycles (ISSUE, done in the first WAIT_DONE cycle, GAP, IDLE evaluation).
- Timeout: res_req in cycle N with no done gives gnt clear and timeout_err set in cycle N+TIMEOUT+1.
- rst mid-transaction: everything returns to reset values on the next edge. No res_req is emitted in the reset cycle or the cycle after it.

## Structure
- Package req_pacer_pkg holds the state enum (`state_e`) and the range-check constants for the parameters.
- One sub-module, rr_pick: a combinational round-robin picker taking `req` and `ptr` and producing a one-hot winner, the winner index and a valid bit.
- The FSM, counters and pointer stay in the top module.
- Parameter legality is checked at elaboration with $error.

## Test plan
- Single requester: req_in=4'b0010 from cycle 2, res_done 3 cycles after res_req → gnt=0010, gnt_id=1, one res_req pulse, busy drops MIN_GAP+1 cycles after done.
- All four requesting continuously, immediate done each time → grant order 0,1,2,3,0; pulses spaced exactly 3+MIN_GAP cycles; assertion never fires.
- No res_done, TIMEOUT=16 → gnt clears and timeout_err=1 at res_req+17; it stays 1 through later good transactions until rst.
- res_done in the ISSUE cycle is ignored; res_done coincident with the final timeout cycle → completion, timeout_err stays 0.
- rst asserted during WAIT_DONE → next cycle all outputs 0 and ptr=0; with requester 2 still requesting, the first post-reset grant goes to requester 2.
- MIN_GAP=0 build → back-to-back transactions with res_req never high on consecutive cycles.
